// File: rtl/err_event_capture.sv
// N-channel error capture: rising-edge detect, sticky first-occurrence flags with timestamps,
// first-word fall-through report FIFO. Define ERR_CAPTURE_COUNT_EN for per-channel saturating counters.
module err_event_capture #(
    parameter int NumChannels = 9,
    parameter int TimeWidth   = 32,
    parameter int CountWidth  = 16,
    parameter int FifoDepth   = 4,
    localparam int ChanW      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumChannels-1:0]            err_i,
    input  logic                              clear_i,
    output logic [NumChannels-1:0]            sticky_o,
    output logic [NumChannels*CountWidth-1:0] count_o,
    output logic                              event_valid_o,
    input  logic                              event_ready_i,
    output logic [ChanW-1:0]                  event_chan_o,
    output logic [TimeWidth-1:0]              event_time_o
);
    localparam int AW = $clog2(FifoDepth);
    localparam logic [AW:0] FullCnt = (AW+1)'(FifoDepth);

    logic [NumChannels-1:0]                err_q, err_d;
    logic [NumChannels-1:0]                sticky_q, sticky_d;
    logic [NumChannels-1:0]                pending_q, pending_d;
    logic [NumChannels-1:0][TimeWidth-1:0] time_q, time_d;
    logic [TimeWidth-1:0]                  timer_q, timer_d;
    logic [AW-1:0]                         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                           fill_q, fill_d;
    logic [ChanW-1:0]                      chan_mem_q [FifoDepth];
    logic [TimeWidth-1:0]                  time_mem_q [FifoDepth];

    logic [NumChannels-1:0] rise, first, drain_mask;
    logic [ChanW-1:0]       sel_chan;
    logic [TimeWidth-1:0]   sel_time;
    logic                   push, pop, full;

    always_comb begin
        err_d   = err_i;
        timer_d = timer_q + 1'b1;
        rise    = err_i & ~err_q;
        // A rise coinciding with clear is seen against the already-cleared sticky state
        first   = rise & ~(clear_i ? '0 : sticky_q);

        sel_chan   = '0;
        sel_time   = '0;
        drain_mask = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_chan   = ChanW'(i);
                sel_time   = time_q[i];
                drain_mask = '0;
                drain_mask[i] = 1'b1;
            end
        end

        full = (fill_q == FullCnt);
        pop  = event_valid_o && event_ready_i;
        push = (|pending_q) && (!full || pop);

        sticky_d  = (clear_i ? '0 : sticky_q) | first;
        pending_d = (clear_i ? '0 : (pending_q & ~(push ? drain_mask : '0))) | first;
        time_d    = time_q;
        for (int i = 0; i < NumChannels; i++)
            if (first[i]) time_d[i] = timer_q;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q     <= '0;
            sticky_q  <= '0;
            pending_q <= '0;
            time_q    <= '0;
            timer_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
        end else begin
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            pending_q <= pending_d;
            time_q    <= time_d;
            timer_q   <= timer_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
        end
    end

    // Storage needs no reset; the head is masked by valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            chan_mem_q[wr_ptr_q] <= sel_chan;
            time_mem_q[wr_ptr_q] <= sel_time;
        end
    end

    assign sticky_o      = sticky_q;
    assign event_valid_o = (fill_q != '0);
    assign event_chan_o  = event_valid_o ? chan_mem_q[rd_ptr_q] : '0;
    assign event_time_o  = event_valid_o ? time_mem_q[rd_ptr_q] : '0;

`ifdef ERR_CAPTURE_COUNT_EN
    logic [NumChannels-1:0][CountWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        for (int i = 0; i < NumChannels; i++) begin
            if (clear_i)
                cnt_d[i] = rise[i] ? CountWidth'(1) : '0;
            else if (rise[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else
                cnt_d[i] = cnt_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
`else
    assign count_o = '0;
`endif
endmodule

// File: tb/tb_err_event_capture.sv
// Directed bench for err_event_capture: latency, dedup, back-pressure, clear, wrap, saturation, reset.
module tb_err_event_capture;
    localparam int NC = 9, TW = 4, CWD = 8, FD = 4;

    logic          clk = 1'b0, rst = 1'b1, clear = 1'b0, ready = 1'b0;
    logic [NC-1:0] err = '0;
    logic [NC-1:0] sticky;
    logic [NC*CWD-1:0] count;
    logic          valid;
    logic [3:0]    chan;
    logic [TW-1:0] etime;
    logic [TW-1:0] tb_t;
    int tests = 0, fails = 0;

    err_event_capture #(.NumChannels(NC), .TimeWidth(TW), .CountWidth(CWD), .FifoDepth(FD)) dut (
        .clk_i(clk), .rst_i(rst), .err_i(err), .clear_i(clear), .sticky_o(sticky),
        .count_o(count), .event_valid_o(valid), .event_ready_i(ready),
        .event_chan_o(chan), .event_time_o(etime));

    always #5 clk = ~clk;

    // Reference free-running timer: holds the DUT timer value between edges
    always @(posedge clk or posedge rst)
        if (rst) tb_t <= '0; else tb_t <= tb_t + 1'b1;

    function automatic logic [CWD-1:0] exp_cnt(input int n);
`ifdef ERR_CAPTURE_COUNT_EN
        return CWD'(n);
`else
        return '0;
`endif
    endfunction

    task automatic wait_time(input int v);
        int hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (tb_t == TW'(v)) hit = 1;
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL wait_time: timer %0d never reached", v); end
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (sticky !== '0) begin fails++; $display("FAIL rst_sticky: got %h want 0", sticky); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
        tests++; if (count !== '0) begin fails++; $display("FAIL rst_count: got %h want 0", count); end
        tests++; if (chan !== '0 || etime !== '0) begin fails++; $display("FAIL rst_head: got %0d/%0d want 0/0", chan, etime); end
    endtask

    task automatic test_single();
        wait_time(10);
        err[3] = 1'b1;
        @(negedge clk); err[3] = 1'b0;
        tests++; if (sticky !== 9'h008) begin fails++; $display("FAIL single_sticky: got %h want 008", sticky); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL single_early: valid %b want 0", valid); end
        @(negedge clk);
        tests++; if (valid !== 1'b1 || chan !== 4'd3 || etime !== 4'd10) begin
            fails++; $display("FAIL single_event: got v=%b c=%0d t=%0d want v=1 c=3 t=10", valid, chan, etime); end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL single_pop: valid %b want 0", valid); end
    endtask

    task automatic test_hold();
        int pops = 0;
        pulse_clear();
        err[0] = 1'b1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            err[0] = 1'b0; @(negedge clk);
            err[0] = 1'b1; @(negedge clk);
        end
        err[0] = 1'b0; @(negedge clk);
        tests++; if (count[0 +: CWD] !== exp_cnt(6)) begin
            fails++; $display("FAIL hold_count: got %0d want %0d", count[0 +: CWD], exp_cnt(6)); end
        ready = 1'b1;
        repeat (10) begin
            if (valid) begin
                pops++;
                tests++; if (chan !== 4'd0) begin fails++; $display("FAIL hold_chan: got %0d want 0", chan); end
            end
            @(negedge clk);
        end
        ready = 1'b0;
        tests++; if (pops != 1) begin fails++; $display("FAIL hold_events: got %0d want 1", pops); end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] t0;
        pulse_clear();
        err = '1; t0 = tb_t;
        @(negedge clk); err = '0;
        repeat (8) @(negedge clk);
        tests++; if (sticky !== 9'h1FF) begin fails++; $display("FAIL burst_sticky: got %h want 1ff", sticky); end
        tests++; if (valid !== 1'b1 || chan !== 4'd0) begin fails++; $display("FAIL burst_head: got v=%b c=%0d want 1/0", valid, chan); end
        ready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            tests++; if (valid !== 1'b1 || chan !== 4'(i) || etime !== t0) begin
                fails++; $display("FAIL burst_drain: got v=%b c=%0d t=%0d want 1/%0d/%0d", valid, chan, etime, i, t0); end
            @(negedge clk);
        end
        ready = 1'b0;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL burst_empty: valid %b want 0", valid); end
    endtask

    task automatic test_clear_rise();
        clear = 1'b1; err[2] = 1'b1;
        @(negedge clk); clear = 1'b0; err[2] = 1'b0;
        tests++; if (sticky !== 9'h004) begin fails++; $display("FAIL clr_sticky: got %h want 004", sticky); end
        tests++; if (count[2*CWD +: CWD] !== exp_cnt(1)) begin
            fails++; $display("FAIL clr_count: got %0d want %0d", count[2*CWD +: CWD], exp_cnt(1)); end
        @(negedge clk);
        tests++; if (valid !== 1'b1 || chan !== 4'd2) begin fails++; $display("FAIL clr_event: got v=%b c=%0d want 1/2", valid, chan); end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        pulse_clear();
        wait_time(15);
        err[5] = 1'b1;
        @(negedge clk); err[5] = 1'b0; err[6] = 1'b1;
        @(negedge clk); err[6] = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (valid !== 1'b1 || chan !== 4'd5 || etime !== 4'd15) begin
            fails++; $display("FAIL wrap_15: got v=%b c=%0d t=%0d want 1/5/15", valid, chan, etime); end
        ready = 1'b1; @(negedge clk);
        tests++; if (valid !== 1'b1 || chan !== 4'd6 || etime !== 4'd0) begin
            fails++; $display("FAIL wrap_0: got v=%b c=%0d t=%0d want 1/6/0", valid, chan, etime); end
        @(negedge clk); ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            err[7] = 1'b1; @(negedge clk);
            err[7] = 1'b0; @(negedge clk);
        end
        tests++; if (count[7*CWD +: CWD] !== exp_cnt(255)) begin
            fails++; $display("FAIL sat_count: got %0d want %0d", count[7*CWD +: CWD], exp_cnt(255)); end
        tests++; if (valid !== 1'b1 || chan !== 4'd7) begin fails++; $display("FAIL sat_event: got v=%b c=%0d want 1/7", valid, chan); end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        pulse_clear();
        err = '1;
        @(negedge clk); err = '0;
        repeat (3) @(negedge clk);
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL rmid_pre: valid %b want 1", valid); end
        rst = 1'b1; #1;
        tests++; if (valid !== 1'b0 || sticky !== '0 || count !== '0 || chan !== '0 || etime !== '0) begin
            fails++; $display("FAIL rmid_outputs: v=%b s=%h c=%h ch=%0d t=%0d want all 0", valid, sticky, count, chan, etime); end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        ready = 1'b1;
        repeat (12) begin @(negedge clk); if (valid) seen++; end
        ready = 1'b0;
        tests++; if (seen != 0 || sticky !== '0) begin
            fails++; $display("FAIL rmid_after: %0d events, sticky %h, want 0/0", seen, sticky); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_clear_rise();
        test_wrap_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
